// File: rtl/skintone_pkg.sv
// Shared types and default constants for the skin-tone chroma cluster blocks
// (width_chroma, mean_cb, mean_cr).
package skintone_pkg;

  typedef enum logic [1:0] {
    REG_LOW,
    REG_MID,
    REG_HIGH
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DIV,
    ST_DONE
  } state_e;

  // Luma knees and legal luma range of the reference skin-tone model
  localparam int DEF_K_L   = 125;
  localparam int DEF_K_H   = 188;
  localparam int DEF_Y_MIN = 16;
  localparam int DEF_Y_MAX = 235;

  localparam int DEF_W_CR  = 39;
  localparam int DEF_WL_CR = 20;
  localparam int DEF_WH_CR = 10;
  localparam int DEF_W_CB  = 47;
  localparam int DEF_WL_CB = 23;
  localparam int DEF_WH_CB = 14;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, QUO_W clocks per divide.
// The caller guarantees num / den < 2**QUO_W and den != 0.
module seq_divider #(
  parameter int NUM_W = 24,
  parameter int DEN_W = 8,
  parameter int QUO_W = NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [QUO_W-1:0] quo
);

  localparam int CW = $clog2(QUO_W + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [DEN_W-1:0] rem_r;
  logic [DEN_W-1:0] den_r;
  logic [QUO_W-1:0] sh;
  logic [DEN_W:0]   trial;
  logic [DEN_W-1:0] diff;
  logic             ok;

  // Remainder stays below den, so the trial value fits in DEN_W+1 bits and
  // the subtraction result fits back into DEN_W bits.
  assign trial = {rem_r, sh[QUO_W-1]};
  assign ok    = (trial >= {1'b0, den_r});
  assign diff  = trial[DEN_W-1:0] - den_r;

  // done marks the cycle whose rising edge writes the last quotient bit;
  // quo then holds until the next start.
  assign done = busy && (cnt == CW'(1));
  assign quo  = sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(QUO_W);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  // sh shifts numerator bits out of the top while quotient bits enter below
  always_ff @(posedge clk) begin
    if (start) begin
      rem_r <= DEN_W'(num >> QUO_W);
      sh    <= num[QUO_W-1:0];
      den_r <= den;
    end else if (busy) begin
      rem_r <= ok ? diff : trial[DEN_W-1:0];
      sh    <= {sh[QUO_W-2:0], ok};
    end
  end

endmodule

// File: rtl/width_chroma.sv
// Luma-dependent chroma cluster width: piecewise-linear taper of the Cr or Cb
// width below K_L and above K_H, constant in between, in Q(DATA_W.FRAC_W).
module width_chroma
  import skintone_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8,
  parameter int K_L    = DEF_K_L,
  parameter int K_H    = DEF_K_H,
  parameter int Y_MIN  = DEF_Y_MIN,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int W_CR   = DEF_W_CR,
  parameter int WL_CR  = DEF_WL_CR,
  parameter int WH_CR  = DEF_WH_CR,
  parameter int W_CB   = DEF_W_CB,
  parameter int WL_CB  = DEF_WL_CB,
  parameter int WH_CB  = DEF_WH_CB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        y,
  input  logic                     sel_cr,
  input  logic                     y_valid,
  output logic                     y_ready,
  output logic [DATA_W+FRAC_W-1:0] width_out,
  output logic                     width_valid,
  input  logic                     width_ready
);

  localparam int QW    = DATA_W + FRAC_W;
  localparam int NUM_W = 2 * DATA_W + FRAC_W;

  // Guarantees a non-zero divisor and a non-negative numerator in both tapers
  if (K_L <= Y_MIN || Y_MAX <= K_H || K_L >= K_H ||
      W_CR < WL_CR || W_CR < WH_CR || W_CB < WL_CB || W_CB < WH_CB) begin : g_bad_params
    $error("width_chroma: illegal knee or width parameters");
  end

  localparam logic [DATA_W-1:0] YMIN_V   = DATA_W'(Y_MIN);
  localparam logic [DATA_W-1:0] YMAX_V   = DATA_W'(Y_MAX);
  localparam logic [DATA_W-1:0] KL_V     = DATA_W'(K_L);
  localparam logic [DATA_W-1:0] KH_V     = DATA_W'(K_H);
  localparam logic [DATA_W-1:0] DEN_LOW  = DATA_W'(K_L - Y_MIN);
  localparam logic [DATA_W-1:0] DEN_HIGH = DATA_W'(Y_MAX - K_H);

  function automatic logic [DATA_W-1:0] clamp_y(input logic [DATA_W-1:0] v);
    if (v < YMIN_V) return YMIN_V;
    if (v > YMAX_V) return YMAX_V;
    return v;
  endfunction

  state_e              state, state_nx;
  region_e             region_nx, region_q;
  logic [DATA_W-1:0]   y_q;
  logic                sel_q;
  logic [DATA_W-1:0]   yc, w_sel, wl_sel, wh_sel, dw, dy, den;
  logic [2*DATA_W-1:0] prod;
  logic [NUM_W-1:0]    num;
  logic [QW-1:0]       base_nx, base_q, quo;
  logic                accept, div_start, div_done;

  assign accept = y_valid && y_ready;

  // Setup datapath: region select and divider operands from the captured sample
  always_comb begin
    yc        = clamp_y(y_q);
    w_sel     = sel_q ? DATA_W'(W_CR)  : DATA_W'(W_CB);
    wl_sel    = sel_q ? DATA_W'(WL_CR) : DATA_W'(WL_CB);
    wh_sel    = sel_q ? DATA_W'(WH_CR) : DATA_W'(WH_CB);
    region_nx = REG_MID;
    dw        = '0;
    dy        = '0;
    den       = DEN_LOW;
    base_nx   = {w_sel, {FRAC_W{1'b0}}};
    if (yc <= KL_V) begin
      region_nx = REG_LOW;
      dw        = w_sel - wl_sel;
      dy        = yc - YMIN_V;
      den       = DEN_LOW;
      base_nx   = {wl_sel, {FRAC_W{1'b0}}};
    end else if (yc >= KH_V) begin
      region_nx = REG_HIGH;
      dw        = w_sel - wh_sel;
      dy        = YMAX_V - yc;
      den       = DEN_HIGH;
      base_nx   = {wh_sel, {FRAC_W{1'b0}}};
    end
    prod = {{DATA_W{1'b0}}, dw} * {{DATA_W{1'b0}}, dy};
    num  = {prod, {FRAC_W{1'b0}}};
  end

  assign div_start = (state == ST_SETUP) && (region_nx != REG_MID);

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DATA_W),
    .QUO_W (QW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (num),
    .den   (den),
    .done  (div_done),
    .quo   (quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SETUP;
      ST_SETUP: state_nx = (region_nx == REG_MID) ? ST_DONE : ST_DIV;
      ST_DIV:   if (div_done) state_nx = ST_DONE;
      ST_DONE:  if (width_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Capture and setup registers carry data only; validity comes from state
  always_ff @(posedge clk) begin
    if (accept) begin
      y_q   <= y;
      sel_q <= sel_cr;
    end
    if (state == ST_SETUP) begin
      region_q <= region_nx;
      base_q   <= base_nx;
    end
  end

  // Result is only exposed in DONE, where base_q, region_q and quo are frozen
  assign y_ready     = (state == ST_IDLE) && !rst;
  assign width_valid = (state == ST_DONE);
  assign width_out   = (state != ST_DONE)     ? '0 :
                       (region_q == REG_MID)  ? base_q : base_q + quo;

endmodule

// File: tb/tb_width_chroma.sv
// Directed and randomised bench for width_chroma with a queue-based scoreboard.
module tb_width_chroma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  y = '0;
  logic        sel_cr = 1'b0;
  logic        y_valid = 1'b0;
  logic        y_ready;
  logic [15:0] width_out;
  logic        width_valid;
  logic        width_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic hs_en = 1'b0;

  logic [15:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  width_chroma dut (
    .clk         (clk),
    .rst         (rst),
    .y           (y),
    .sel_cr      (sel_cr),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .width_out   (width_out),
    .width_valid (width_valid),
    .width_ready (width_ready)
  );

  always @(posedge clk) if (hs_en && width_valid && width_ready) hs_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: straight evaluation of the taper formulas with integers
  function automatic int model_w(input int yy, input int s);
    int w, wl, wh, yc;
    w  = s ? 39 : 47;
    wl = s ? 20 : 23;
    wh = s ? 10 : 14;
    yc = (yy < 16) ? 16 : ((yy > 235) ? 235 : yy);
    if (yc <= 125) return wl * 256 + ((w - wl) * (yc - 16) * 256) / 109;
    if (yc >= 188) return wh * 256 + ((w - wh) * (235 - yc) * 256) / 47;
    return w * 256;
  endfunction

  function automatic int model_lat(input int yy);
    int yc;
    yc = (yy < 16) ? 16 : ((yy > 235) ? 235 : yy);
    return (yc > 125 && yc < 188) ? 1 : 17;
  endfunction

  // One transaction; latency is counted in rising edges after the accept edge
  task automatic run_txn(input logic [7:0] yy, input logic s, input logic [15:0] ew,
                         input int elat, input int hold);
    int n;
    int lat;
    logic [15:0] pw;
    int plat;
    exp_q.push_back(ew);
    lat_q.push_back(elat);
    @(negedge clk);
    y = yy;
    sel_cr = s;
    y_valid = 1'b1;
    width_ready = 1'b0;
    n = 0;
    while (!y_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(y_ready), 32'd1);
    @(posedge clk);
    #1;
    // keep offering a different sample while busy: it must be ignored
    y = 8'h00;
    sel_cr = ~s;
    check("ready_low_after_accept", 32'(y_ready), 32'd0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (width_valid) break;
    end
    pw = exp_q.pop_front();
    plat = lat_q.pop_front();
    check("latency", 32'(lat), 32'(plat));
    check("width_out", 32'(width_out), 32'(pw));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_width", 32'(width_out), 32'(pw));
      check("hold_valid_ready", {30'd0, width_valid, y_ready}, 32'd2);
    end
    y_valid = 1'b0;
    width_ready = 1'b1;
    @(posedge clk);
    #1;
    width_ready = 1'b0;
    check("ready_after_consume", 32'(y_ready), 32'd1);
    check("valid_after_consume", 32'(width_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] ry;
    logic rs;

    #1;
    check("rst_ready", 32'(y_ready), 32'd0);
    check("rst_valid", 32'(width_valid), 32'd0);
    check("rst_width", 32'(width_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_first_after_rst", 32'(y_ready), 32'd1);

    run_txn(8'd70,  1'b1, 16'h1D69, 17, 0);
    run_txn(8'd200, 1'b1, 16'h1F98, 17, 10);
    run_txn(8'd235, 1'b1, 16'h0A00, 17, 0);
    run_txn(8'd150, 1'b1, 16'h2700, 1,  0);
    run_txn(8'd5,   1'b1, 16'h1400, 17, 0);
    run_txn(8'd125, 1'b0, 16'h2F00, 17, 0);
    run_txn(8'd126, 1'b0, 16'h2F00, 1,  0);
    run_txn(8'd188, 1'b0, 16'(model_w(188, 0)), 17, 0);
    run_txn(8'd187, 1'b1, 16'h2700, 1,  2);
    run_txn(8'd255, 1'b0, 16'h0E00, 17, 0);

    for (int i = 0; i < 8; i++) begin
      ry = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_txn(ry, rs, 16'(model_w(int'(ry), int'(rs))), model_lat(int'(ry)), 0);
    end

    // Reset in the middle of a divide must drop that result entirely
    @(negedge clk);
    y = 8'd70;
    sel_cr = 1'b1;
    y_valid = 1'b1;
    @(posedge clk);
    #1;
    y_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(y_ready), 32'd0);
    check("midrst_valid", 32'(width_valid), 32'd0);
    check("midrst_width", 32'(width_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hs_en = 1'b1;
    #1;
    check("midrst_ready_release", 32'(y_ready), 32'd1);
    run_txn(8'd16, 1'b1, 16'h1400, 17, 0);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_single_output", 32'(hs_cnt), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/width_chroma.md
WIDTH_CHROMA -- requirements
Module: width_chroma

Interface
REQ-001 Parameter DATA_W, default 8, luma sample width in bits.
REQ-002 Parameter FRAC_W, default 8, fractional bits of the width result.
REQ-003 Parameter K_L, default 125, lower luma knee.
REQ-004 Parameter K_H, default 188, upper luma knee.
REQ-005 Parameter Y_MIN, default 16, luma floor; Y_MAX, default 235, luma ceiling.
REQ-006 Parameters W_CR/WL_CR/WH_CR, defaults 39/20/10, Cr cluster widths (integer).
REQ-007 Parameters W_CB/WL_CB/WH_CB, defaults 47/23/14, Cb cluster widths (integer).
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 y  in  DATA_W  luma sample.
REQ-011 sel_cr  in  1  1 = Cr width set, 0 = Cb width set; sampled with y.
REQ-012 y_valid  in  1  input sample valid.
REQ-013 y_ready  out  1  block can accept a sample.
REQ-014 width_out  out  DATA_W+FRAC_W  cluster width, unsigned fixed point Q(DATA_W.FRAC_W).
REQ-015 width_valid  out  1  width_out valid.
REQ-016 width_ready  in  1  downstream accepts width_out.

Function
REQ-017 The block SHALL accept a sample on a rising edge where y_valid && y_ready, capturing y and sel_cr.
REQ-018 The block SHALL clamp y to [Y_MIN, Y_MAX] before use.
REQ-019 Region SHALL be LOW if Yc <= K_L, HIGH if Yc >= K_H, MID otherwise.
REQ-020 LOW: width = WL + floor(((W-WL)*(Yc-Y_MIN) << FRAC_W) / (K_L-Y_MIN)).
REQ-021 HIGH: width = WH + floor(((W-WH)*(Y_MAX-Yc) << FRAC_W) / (Y_MAX-K_H)).
REQ-022 MID: width = W << FRAC_W, with no division.
REQ-023 W, WL and WH SHALL be the Cr or Cb set, as selected by the captured sel_cr.
REQ-024 Quotient width SHALL be QW = DATA_W+FRAC_W bits; numerator width 2*DATA_W+FRAC_W; results SHALL truncate.
REQ-025 Division SHALL be a restoring iterative divider producing one quotient bit per clock, QW clocks total.
REQ-026 FSM states: IDLE, SETUP, DIV, DONE.
 - IDLE: y_ready=1; accept -> SETUP.
 - SETUP: register region, numerator and divisor; MID -> DONE, else -> DIV.
 - DIV: QW cycles -> DONE.
 - DONE: width_valid=1, width_out held stable; width_ready -> IDLE.
REQ-027 y_ready SHALL be 1 only in IDLE, so y_valid outside IDLE is not accepted.
REQ-028 Latency from accept edge N SHALL be: width_valid high in cycle N+2 for MID, N+2+QW for LOW/HIGH.
REQ-029 With width_ready held low, width_out and width_valid SHALL remain unchanged indefinitely.
REQ-030 When the output is consumed, y_ready SHALL rise in the next cycle; there is no accept in the same cycle as the output handshake.
REQ-031 Elaboration SHALL fail if K_L <= Y_MIN, Y_MAX <= K_H, K_L >= K_H, or any W < WL or W < WH, so that the divisor is never zero and the numerator is never negative.

Reset
REQ-032 While rst is high: state = IDLE, width_out = 0, width_valid = 0, y_ready = 0.
REQ-033 y_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Reset mid-DIV or mid-DONE SHALL discard the result with no output pulse.

Structure
REQ-035 Package skintone_pkg SHALL hold the region enum, the FSM state enum, and the Cr/Cb default width and knee constants shared with mean_cb/mean_cr blocks.
REQ-036 The divider SHALL be a sub-module seq_divider (parameter NUM_W, DEN_W; start/done handshake), reusable by the mean blocks.

Verification
REQ-037 Default params, sel_cr=1, y=70 -> width_out=0x1D69 at N+18.
REQ-038 sel_cr=1, y=200 -> 0x1F98 at N+18; y=235 -> 0x0A00.
REQ-039 sel_cr=1, y=150 -> 0x2700 at N+2; y=5 (clamped) -> 0x1400.
REQ-040 sel_cr=0, y=125 (K_L boundary, LOW) -> 0x2F00.
REQ-041 Hold width_ready=0 for 10 cycles after valid -> width_out stable, y_ready=0; then release -> y_ready=1 the next cycle.
REQ-042 Assert rst at DIV cycle 5, release, then send y=16 with sel_cr=1 -> exactly one output, 0x1400.
